aq_sysio_sync: RTL and testbench

System-IO front stage directly upstream of the CPU IO top.
- Synchronizes the six asynchronous pad interrupt lines into the core clock domain and feeds them to the CPU IO top as sysio_cpuio_*_int.
- Captures and holds the reset vector base (rvba) once after reset.
- Converts the core's low-power mode code into a request/acknowledge handshake with the SoC power controller, with a timeout and interrupt wakeup.

---
 rtl/aq_sysio_sync.sv | 158 +++++++++++++++
 tb/tb_aq_sysio_sync.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_sysio_sync.sv
// System-IO front stage: pad interrupt/ack synchronizers, reset-vector capture and low-power
// request/ack handshake. Define AQ_SYSIO_SYNC3_EN to force 3-stage synchronizers.
module aq_sysio_sync #(
   parameter int unsigned          SYNC_STAGES = 2,
   parameter int unsigned          LPMD_TO_W   = 8,
   parameter logic [LPMD_TO_W-1:0] LPMD_TO_VAL = LPMD_TO_W'(200)
) (
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        pad_sysio_me_int,
   input  logic        pad_sysio_ms_int,
   input  logic        pad_sysio_mt_int,
   input  logic        pad_sysio_se_int,
   input  logic        pad_sysio_ss_int,
   input  logic        pad_sysio_st_int,
   input  logic [39:0] pad_sysio_rvba,
   input  logic        pad_sysio_lpmd_ack,
   input  logic [1:0]  cpuio_sysio_lpmd_b,
   output logic        sysio_cpuio_me_int,
   output logic        sysio_cpuio_ms_int,
   output logic        sysio_cpuio_mt_int,
   output logic        sysio_cpuio_se_int,
   output logic        sysio_cpuio_ss_int,
   output logic        sysio_cpuio_st_int,
   output logic [39:0] sysio_xx_rvba,
   output logic [1:0]  sysio_pad_lpmd_b,
   output logic        sysio_xx_wakeup,
   output logic        sysio_xx_lpmd_abort
);

`ifdef AQ_SYSIO_SYNC3_EN
   localparam int unsigned Stages = 3;
`else
   localparam int unsigned Stages = SYNC_STAGES;
`endif

   typedef enum logic [1:0] {StRun, StReq, StLp, StWake} state_e;

   // Bits [5:0] are the interrupts (me, ms, mt, se, ss, st), bit 6 is the ack.
   logic [6:0] async_in;
   logic [6:0] sync_q [Stages];
   logic [6:0] sync_out;
   logic       ack_s;
   logic       int_any;

   assign async_in = {pad_sysio_lpmd_ack, pad_sysio_st_int, pad_sysio_ss_int, pad_sysio_se_int,
                      pad_sysio_mt_int, pad_sysio_ms_int, pad_sysio_me_int};

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         for (int i = 0; i < Stages; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= async_in;
         for (int i = 1; i < Stages; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_out = sync_q[Stages-1];
   assign ack_s    = sync_out[6];
   assign int_any  = |sync_out[5:0];

   assign sysio_cpuio_me_int = sync_out[0];
   assign sysio_cpuio_ms_int = sync_out[1];
   assign sysio_cpuio_mt_int = sync_out[2];
   assign sysio_cpuio_se_int = sync_out[3];
   assign sysio_cpuio_ss_int = sync_out[4];
   assign sysio_cpuio_st_int = sync_out[5];

   // Reset vector base: sampled on the first edge after reset, then frozen.
   logic        rvba_vld_q;
   logic [39:0] rvba_q;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rvba_vld_q <= 1'b0;
         rvba_q     <= '0;
      end else if (!rvba_vld_q) begin
         rvba_vld_q <= 1'b1;
         rvba_q     <= pad_sysio_rvba;
      end
   end

   assign sysio_xx_rvba = rvba_q;

   // Low-power handshake FSM with registered outputs.
   state_e               state_q;
   logic [1:0]           lpmd_q;
   logic [1:0]           mode_q;
   logic [1:0]           lpmd_out_q;
   logic [LPMD_TO_W-1:0] cnt_q;
   logic                 wakeup_q;
   logic                 abort_q;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q    <= StRun;
         lpmd_q     <= 2'b11;
         mode_q     <= 2'b11;
         lpmd_out_q <= 2'b11;
         cnt_q      <= '0;
         wakeup_q   <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         lpmd_q   <= cpuio_sysio_lpmd_b;
         wakeup_q <= 1'b0;
         abort_q  <= 1'b0;
         case (state_q)
            StRun: begin
               lpmd_out_q <= 2'b11;
               // A still-high ack from a previous handshake blocks a new request.
               if (lpmd_q != 2'b11 && !ack_s) begin
                  mode_q     <= lpmd_q;
                  cnt_q      <= '0;
                  lpmd_out_q <= lpmd_q;
                  state_q    <= StReq;
               end
            end
            StReq: begin
               if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
               if (ack_s) begin
                  state_q <= StLp;
               end else if (int_any) begin
                  state_q    <= StWake;
                  wakeup_q   <= 1'b1;
                  lpmd_out_q <= 2'b11;
               end else if (cnt_q == LPMD_TO_VAL - 1'b1) begin
                  state_q    <= StRun;
                  abort_q    <= 1'b1;
                  lpmd_out_q <= 2'b11;
               end
            end
            StLp: begin
               if (int_any) begin
                  state_q    <= StWake;
                  wakeup_q   <= 1'b1;
                  lpmd_out_q <= 2'b11;
               end else if (lpmd_q == 2'b11) begin
                  state_q    <= StWake;
                  lpmd_out_q <= 2'b11;
               end
            end
            StWake: begin
               lpmd_out_q <= 2'b11;
               if (!ack_s) state_q <= StRun;
            end
            default: begin
               state_q    <= StRun;
               lpmd_out_q <= 2'b11;
            end
         endcase
      end
   end

   assign sysio_pad_lpmd_b    = lpmd_out_q;
   assign sysio_xx_wakeup     = wakeup_q;
   assign sysio_xx_lpmd_abort = abort_q;

endmodule

// File: tb/tb_aq_sysio_sync.sv
// Bench for aq_sysio_sync: directed handshake scenarios plus randomized traffic, all checked
// every cycle against a cycle-level behavioural model of the pad/low-power interface.
module tb_aq_sysio_sync;

`ifdef AQ_SYSIO_SYNC3_EN
   localparam int S = 3;
`else
   localparam int S = 2;
`endif
   localparam int ToVal = 200;
   localparam int PhRun = 0, PhReq = 1, PhLp = 2, PhWake = 3;

   logic        clk;
   logic        rst_n;
   logic        me, ms, mt, se, ss, st;
   logic [39:0] rvba;
   logic        ack;
   logic [1:0]  lpmd;
   logic        o_me, o_ms, o_mt, o_se, o_ss, o_st;
   logic [39:0] o_rvba;
   logic [1:0]  o_lpmd;
   logic        o_wake, o_abort;

   aq_sysio_sync dut (
      .forever_cpuclk      (clk),
      .cpurst_b            (rst_n),
      .pad_sysio_me_int    (me),
      .pad_sysio_ms_int    (ms),
      .pad_sysio_mt_int    (mt),
      .pad_sysio_se_int    (se),
      .pad_sysio_ss_int    (ss),
      .pad_sysio_st_int    (st),
      .pad_sysio_rvba      (rvba),
      .pad_sysio_lpmd_ack  (ack),
      .cpuio_sysio_lpmd_b  (lpmd),
      .sysio_cpuio_me_int  (o_me),
      .sysio_cpuio_ms_int  (o_ms),
      .sysio_cpuio_mt_int  (o_mt),
      .sysio_cpuio_se_int  (o_se),
      .sysio_cpuio_ss_int  (o_ss),
      .sysio_cpuio_st_int  (o_st),
      .sysio_xx_rvba       (o_rvba),
      .sysio_pad_lpmd_b    (o_lpmd),
      .sysio_xx_wakeup     (o_wake),
      .sysio_xx_lpmd_abort (o_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   bit chk_en  = 1'b0;

   // Behavioural model: synchronizers are pure S-cycle delays of the sampled pads.
   logic [6:0]  hist[$];
   logic [5:0]  m_int;
   logic [39:0] m_rvba;
   logic        m_vld;
   logic [1:0]  m_lpmd_q, m_mode, m_out;
   logic        m_wake, m_abort;
   int          m_ph, m_age;

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back(7'd0);
      m_int = '0; m_rvba = '0; m_vld = 1'b0; m_lpmd_q = 2'b11; m_mode = 2'b11;
      m_out = 2'b11; m_wake = 1'b0; m_abort = 1'b0; m_ph = PhRun; m_age = 0;
   endtask

   task automatic model_step();
      logic [6:0] s;
      if (!rst_n) begin
         model_reset();
         return;
      end
      s = hist[0];
      m_wake  = 1'b0;
      m_abort = 1'b0;
      case (m_ph)
         PhRun: if (m_lpmd_q != 2'b11 && !s[6]) begin
            m_mode = m_lpmd_q; m_age = 0; m_ph = PhReq;
         end
         PhReq: begin
            m_age++;
            if (s[6]) m_ph = PhLp;
            else if (|s[5:0]) begin m_ph = PhWake; m_wake = 1'b1; end
            else if (m_age == ToVal) begin m_ph = PhRun; m_abort = 1'b1; end
         end
         PhLp: begin
            if (|s[5:0]) begin m_ph = PhWake; m_wake = 1'b1; end
            else if (m_lpmd_q == 2'b11) m_ph = PhWake;
         end
         default: if (!s[6]) m_ph = PhRun;
      endcase
      m_out = (m_ph == PhReq || m_ph == PhLp) ? m_mode : 2'b11;
      m_lpmd_q = lpmd;
      hist.push_back({ack, st, ss, se, mt, ms, me});
      void'(hist.pop_front());
      m_int = hist[0][5:0];
      if (!m_vld) begin m_rvba = rvba; m_vld = 1'b1; end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("int", 64'({o_st, o_ss, o_se, o_mt, o_ms, o_me}), 64'(m_int));
         check("rvba", 64'(o_rvba), 64'(m_rvba));
         check("lpmd_out", 64'(o_lpmd), 64'(m_out));
         check("wakeup", 64'(o_wake), 64'(m_wake));
         check("abort", 64'(o_abort), 64'(m_abort));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_lpmd", 64'(o_lpmd), 64'd3);
      check("rst_wake_abort", 64'({o_wake, o_abort}), 64'd0);
      check("rst_rvba", 64'(o_rvba), 64'd0);
      tick(2);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      {me, ms, mt, se, ss, st} = '0;
      ack  = 1'b0;
      lpmd = 2'b11;
      rvba = 40'h00_8000_0000;
      model_reset();
      #1;
      chk_en = 1'b1;
      do_reset();

      // rvba capture, then interrupt latency
      tick(4);
      rvba = 40'h12_3456_7890;
      tick(1);
      check("rvba_frozen", 64'(o_rvba), 64'h00_8000_0000);
      tick(4);
      mt = 1'b1;
      tick(S - 1);
      check("mt_before", 64'(o_mt), 64'd0);
      tick(1);
      check("mt_rise", 64'(o_mt), 64'd1);
      tick(5 - S);
      mt = 1'b0;
      tick(S - 1);
      check("mt_hold", 64'(o_mt), 64'd1);
      tick(1);
      check("mt_fall", 64'(o_mt), 64'd0);

      // full handshake with interrupt wakeup
      lpmd = 2'b10;
      tick(1);
      check("req_lat1", 64'(o_lpmd), 64'd3);
      tick(1);
      check("req_lat2", 64'(o_lpmd), 64'd2);
      ack = 1'b1;
      tick(S + 1);
      se = 1'b1;
      tick(S);
      check("lp_out", 64'({o_lpmd, o_wake}), 64'({2'b10, 1'b0}));
      tick(1);
      check("wake_pulse", 64'({o_lpmd, o_wake}), 64'({2'b11, 1'b1}));
      tick(1);
      check("wake_single", 64'(o_wake), 64'd0);
      lpmd = 2'b11;
      se   = 1'b0;
      tick(3);
      ack = 1'b0;
      tick(S + 2);

      // timeout abort
      lpmd = 2'b00;
      tick(2);
      check("to_req", 64'(o_lpmd), 64'd0);
      lpmd = 2'b11;
      tick(ToVal - 1);
      check("to_early", 64'({o_abort, o_lpmd}), 64'({1'b0, 2'b00}));
      tick(1);
      check("to_abort", 64'({o_abort, o_wake, o_lpmd}), 64'({1'b1, 1'b0, 2'b11}));
      tick(1);
      check("to_single", 64'(o_abort), 64'd0);

      // core-initiated exit
      lpmd = 2'b01;
      tick(2);
      ack = 1'b1;
      tick(S + 2);
      lpmd = 2'b11;
      tick(1);
      check("cx_lp", 64'(o_lpmd), 64'd1);
      tick(1);
      check("cx_wake", 64'({o_lpmd, o_wake}), 64'({2'b11, 1'b0}));
      ack = 1'b0;
      tick(S + 2);

      // reset mid-handshake, then stale ack
      lpmd = 2'b01;
      tick(2);
      ack = 1'b1;
      tick(S + 2);
      check("mid_lp", 64'(o_lpmd), 64'd1);
      lpmd = 2'b11;
      do_reset();
      tick(S);
      check("rvba_recap", 64'(o_rvba), 64'h12_3456_7890);
      lpmd = 2'b01;
      tick(4);
      check("stale_run", 64'(o_lpmd), 64'd3);
      ack = 1'b0;
      tick(S);
      check("stale_hold", 64'(o_lpmd), 64'd3);
      tick(1);
      check("stale_req", 64'(o_lpmd), 64'd1);
      ack = 1'b1;
      tick(S + 2);
      lpmd = 2'b11;
      tick(3);
      ack = 1'b0;
      tick(S + 2);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 15) == 0) me = ~me;
         if ($urandom_range(0, 15) == 0) ms = ~ms;
         if ($urandom_range(0, 15) == 0) mt = ~mt;
         if ($urandom_range(0, 15) == 0) se = ~se;
         if ($urandom_range(0, 15) == 0) ss = ~ss;
         if ($urandom_range(0, 15) == 0) st = ~st;
         if ($urandom_range(0, 9) == 0) ack = ~ack;
         if ($urandom_range(0, 19) == 0) lpmd = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) rvba = {8'($urandom), $urandom};
         if ($urandom_range(0, 599) == 0) do_reset();
         tick(1);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
